// File: rtl/neighbor_qtable_if.sv
// rtl/neighbor_qtable_if.sv - request/result bundle for the neighbor Q-table
interface neighbor_qtable_if #(
  parameter int WORD_WIDTH    = 16,
  parameter int MAX_NEIGHBORS = 32
);
  localparam int IDX_W = $clog2(MAX_NEIGHBORS);

  logic                  en;
  logic                  iAmDestination;
  logic                  HB_Reset;
  logic [WORD_WIDTH-1:0] fSourceID;
  logic [WORD_WIDTH-1:0] fSourceHops;
  logic [WORD_WIDTH-1:0] fQValue;
  logic [WORD_WIDTH-1:0] fEnergyLeft;

  logic [WORD_WIDTH-1:0] nodeID;
  logic [WORD_WIDTH-1:0] nodeHops;
  logic [WORD_WIDTH-1:0] nodeEnergy;
  logic [WORD_WIDTH-1:0] nodeQValue;
  logic [IDX_W-1:0]      neighborIndex;
  logic [WORD_WIDTH-1:0] chosenHop;
  logic [IDX_W:0]        neighborCount;
  logic                  tableFull;
  logic                  busy;
  logic                  QTUFMB_done;

  modport master (
    output en, iAmDestination, HB_Reset, fSourceID, fSourceHops, fQValue, fEnergyLeft,
    input  nodeID, nodeHops, nodeEnergy, nodeQValue, neighborIndex, chosenHop,
    input  neighborCount, tableFull, busy, QTUFMB_done
  );

  modport slave (
    input  en, iAmDestination, HB_Reset, fSourceID, fSourceHops, fQValue, fEnergyLeft,
    output nodeID, nodeHops, nodeEnergy, nodeQValue, neighborIndex, chosenHop,
    output neighborCount, tableFull, busy, QTUFMB_done
  );
endinterface

// File: rtl/neighbor_qtable.sv
// rtl/neighbor_qtable.sv - neighbor table with Q-value based next-hop selection
// Each request scans the table once to update it, then once more to pick the best neighbor.
module neighbor_qtable #(
  parameter int WORD_WIDTH     = 16,
  parameter int MAX_NEIGHBORS  = 32,
  parameter int REPLACE_POLICY = 0
) (
  input logic              clk,
  input logic              rst,
  neighbor_qtable_if.slave bus
);
  localparam int IDX_W = $clog2(MAX_NEIGHBORS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_NEIGHBORS - 1);
  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W + 1)'(MAX_NEIGHBORS);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITE, SEARCH, DONE} state_t;
  state_t state, state_nxt;

  logic [WORD_WIDTH-1:0]    id_mem     [MAX_NEIGHBORS];
  logic [WORD_WIDTH-1:0]    hops_mem   [MAX_NEIGHBORS];
  logic [WORD_WIDTH-1:0]    q_mem      [MAX_NEIGHBORS];
  logic [WORD_WIDTH-1:0]    energy_mem [MAX_NEIGHBORS];
  logic [MAX_NEIGHBORS-1:0] valid;

  logic [WORD_WIDTH-1:0] lat_id, lat_hops, lat_q, lat_energy;
  logic                  lat_dest;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W:0]        count;

  logic                  match_found, free_found, min_found;
  logic [IDX_W-1:0]      match_idx, free_idx, min_idx;
  logic [WORD_WIDTH-1:0] min_q;

  logic                  best_found;
  logic [IDX_W-1:0]      best_idx;
  logic [WORD_WIDTH-1:0] best_id, best_hops, best_q, best_energy;

  logic [WORD_WIDTH-1:0] node_id, node_hops, node_energy, node_q, chosen_hop;
  logic [IDX_W-1:0]      node_idx;

  logic                  cur_valid;
  logic [WORD_WIDTH-1:0] cur_id, cur_hops, cur_q, cur_energy;
  logic                  last;

  logic                  wr_en, wr_new;
  logic [IDX_W-1:0]      wr_idx;

  logic                  cand_better, fin_found;
  logic [IDX_W-1:0]      fin_idx;
  logic [WORD_WIDTH-1:0] fin_id, fin_hops, fin_q, fin_energy;

  assign cur_valid  = valid[idx];
  assign cur_id     = id_mem[idx];
  assign cur_hops   = hops_mem[idx];
  assign cur_q      = q_mem[idx];
  assign cur_energy = energy_mem[idx];
  assign last       = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en) state_nxt = LOOKUP;
      LOOKUP:  if (last) state_nxt = WRITE;
      WRITE:   state_nxt = lat_dest ? DONE : SEARCH;
      SEARCH:  if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.HB_Reset) state_nxt = IDLE;
  end

  // A full table only admits a newcomer (policy 1) if it strictly beats the weakest entry.
  always_comb begin
    wr_en  = 1'b0;
    wr_new = 1'b0;
    wr_idx = match_idx;
    if (state == WRITE && !bus.HB_Reset) begin
      if (match_found) begin
        wr_en = 1'b1;
      end else if (free_found) begin
        wr_en  = 1'b1;
        wr_new = 1'b1;
        wr_idx = free_idx;
      end else if (REPLACE_POLICY == 1 && min_found && lat_q > min_q) begin
        wr_en  = 1'b1;
        wr_idx = min_idx;
      end
    end
  end

  // Strict comparisons keep the earlier slot on a full tie.
  always_comb begin
    cand_better = cur_valid && (!best_found
                  || (cur_q > best_q)
                  || (cur_q == best_q && cur_hops < best_hops)
                  || (cur_q == best_q && cur_hops == best_hops && cur_energy > best_energy));
    fin_found  = best_found | cur_valid;
    fin_idx    = cand_better ? idx        : best_idx;
    fin_id     = cand_better ? cur_id     : best_id;
    fin_hops   = cand_better ? cur_hops   : best_hops;
    fin_q      = cand_better ? cur_q      : best_q;
    fin_energy = cand_better ? cur_energy : best_energy;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      id_mem[wr_idx]     <= lat_id;
      hops_mem[wr_idx]   <= lat_hops;
      q_mem[wr_idx]      <= lat_q;
      energy_mem[wr_idx] <= lat_energy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= '0;
      count       <= '0;
      idx         <= '0;
      lat_id      <= '0;
      lat_hops    <= '0;
      lat_q       <= '0;
      lat_energy  <= '0;
      lat_dest    <= 1'b0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      min_found   <= 1'b0;
      min_idx     <= '0;
      min_q       <= '0;
      best_found  <= 1'b0;
      best_idx    <= '0;
      best_id     <= '0;
      best_hops   <= '0;
      best_q      <= '0;
      best_energy <= '0;
      node_id     <= '0;
      node_hops   <= '0;
      node_energy <= '0;
      node_q      <= '0;
      node_idx    <= '0;
      chosen_hop  <= '0;
    end else if (bus.HB_Reset) begin
      valid      <= '0;
      count      <= '0;
      idx        <= '0;
      chosen_hop <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            lat_id      <= bus.fSourceID;
            lat_hops    <= bus.fSourceHops;
            lat_q       <= bus.fQValue;
            lat_energy  <= bus.fEnergyLeft;
            lat_dest    <= bus.iAmDestination;
            idx         <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            min_found   <= 1'b0;
          end
        end
        LOOKUP: begin
          if (cur_valid && cur_id == lat_id && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (!cur_valid && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          if (cur_valid && (!min_found || cur_q < min_q)) begin
            min_found <= 1'b1;
            min_idx   <= idx;
            min_q     <= cur_q;
          end
          idx <= last ? '0 : idx + 1'b1;
        end
        WRITE: begin
          if (wr_new) begin
            valid[wr_idx] <= 1'b1;
            count         <= count + 1'b1;
          end
          if (lat_dest) chosen_hop <= '1;
          best_found <= 1'b0;
          idx        <= '0;
        end
        SEARCH: begin
          best_found  <= fin_found;
          best_idx    <= fin_idx;
          best_id     <= fin_id;
          best_hops   <= fin_hops;
          best_q      <= fin_q;
          best_energy <= fin_energy;
          idx         <= last ? '0 : idx + 1'b1;
          if (last && fin_found) begin
            node_id     <= fin_id;
            node_hops   <= fin_hops;
            node_energy <= fin_energy;
            node_q      <= fin_q;
            node_idx    <= fin_idx;
            chosen_hop  <= fin_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.nodeID        = node_id;
  assign bus.nodeHops      = node_hops;
  assign bus.nodeEnergy    = node_energy;
  assign bus.nodeQValue    = node_q;
  assign bus.neighborIndex = node_idx;
  assign bus.chosenHop     = chosen_hop;
  assign bus.neighborCount = count;
  assign bus.tableFull     = (count == FULL_CNT);
  assign bus.busy          = (state != IDLE);
  assign bus.QTUFMB_done   = (state == DONE);
endmodule

// File: tb/tb_neighbor_qtable.sv
// tb/tb_neighbor_qtable.sv - bench for neighbor_qtable, both replace policies side by side
module tb_neighbor_qtable;
  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  neighbor_qtable_if #(.WORD_WIDTH(W), .MAX_NEIGHBORS(N)) ifa ();
  neighbor_qtable_if #(.WORD_WIDTH(W), .MAX_NEIGHBORS(N)) ifb ();

  assign ifb.en             = ifa.en;
  assign ifb.iAmDestination = ifa.iAmDestination;
  assign ifb.HB_Reset       = ifa.HB_Reset;
  assign ifb.fSourceID      = ifa.fSourceID;
  assign ifb.fSourceHops    = ifa.fSourceHops;
  assign ifb.fQValue        = ifa.fQValue;
  assign ifb.fEnergyLeft    = ifa.fEnergyLeft;

  neighbor_qtable #(.WORD_WIDTH(W), .MAX_NEIGHBORS(N), .REPLACE_POLICY(0)) u_p0 (
    .clk(clk), .rst(rst), .bus(ifa));
  neighbor_qtable #(.WORD_WIDTH(W), .MAX_NEIGHBORS(N), .REPLACE_POLICY(1)) u_p1 (
    .clk(clk), .rst(rst), .bus(ifb));

  // Reference: table contents plus the last published selection, per policy.
  bit           m_valid [2][N];
  logic [W-1:0] m_id    [2][N];
  logic [W-1:0] m_hops  [2][N];
  logic [W-1:0] m_q     [2][N];
  logic [W-1:0] m_e     [2][N];
  int           m_count [2];
  logic [W-1:0] m_node_id [2], m_node_hops [2], m_node_e [2], m_node_q [2], m_chosen [2];
  int           m_index [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++) m_valid[p][i] = 1'b0;
      m_count[p] = 0; m_node_id[p] = '0; m_node_hops[p] = '0; m_node_e[p] = '0;
      m_node_q[p] = '0; m_chosen[p] = '0; m_index[p] = 0;
    end
  endtask

  task automatic model_hb();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++) m_valid[p][i] = 1'b0;
      m_count[p] = 0;
      m_chosen[p] = '0;
    end
  endtask

  task automatic model_op(input int p, input logic [W-1:0] id, h, q, e, input bit dest);
    int slot, mi, best;
    slot = -1;
    for (int i = 0; i < N; i++)
      if (slot < 0 && m_valid[p][i] && m_id[p][i] == id) slot = i;
    if (slot < 0)
      for (int i = 0; i < N; i++)
        if (slot < 0 && !m_valid[p][i]) begin
          slot = i; m_valid[p][i] = 1'b1; m_count[p]++;
        end
    if (slot < 0 && p == 1) begin
      mi = 0;
      for (int i = 1; i < N; i++) if (m_q[p][i] < m_q[p][mi]) mi = i;
      if (q > m_q[p][mi]) slot = mi;
    end
    if (slot >= 0) begin
      m_id[p][slot] = id; m_hops[p][slot] = h; m_q[p][slot] = q; m_e[p][slot] = e;
    end
    if (dest) begin
      m_chosen[p] = '1;
    end else begin
      best = -1;
      for (int i = 0; i < N; i++) begin
        if (!m_valid[p][i]) continue;
        if (best < 0 || m_q[p][i] > m_q[p][best]
            || (m_q[p][i] == m_q[p][best] && m_hops[p][i] < m_hops[p][best])
            || (m_q[p][i] == m_q[p][best] && m_hops[p][i] == m_hops[p][best]
                && m_e[p][i] > m_e[p][best]))
          best = i;
      end
      if (best >= 0) begin
        m_node_id[p] = m_id[p][best]; m_node_hops[p] = m_hops[p][best];
        m_node_e[p] = m_e[p][best]; m_node_q[p] = m_q[p][best];
        m_index[p] = best; m_chosen[p] = m_id[p][best];
      end
    end
  endtask

  task automatic check_dut(input int p);
    string pre;
    pre = (p == 0) ? "p0" : "p1";
    chk({pre, "_chosenHop"},  p == 0 ? ifa.chosenHop  : ifb.chosenHop,  m_chosen[p]);
    chk({pre, "_nodeID"},     p == 0 ? ifa.nodeID     : ifb.nodeID,     m_node_id[p]);
    chk({pre, "_nodeHops"},   p == 0 ? ifa.nodeHops   : ifb.nodeHops,   m_node_hops[p]);
    chk({pre, "_nodeEnergy"}, p == 0 ? ifa.nodeEnergy : ifb.nodeEnergy, m_node_e[p]);
    chk({pre, "_nodeQValue"}, p == 0 ? ifa.nodeQValue : ifb.nodeQValue, m_node_q[p]);
    chk({pre, "_neighborIndex"}, p == 0 ? ifa.neighborIndex : ifb.neighborIndex, 64'(m_index[p]));
    chk({pre, "_neighborCount"}, p == 0 ? ifa.neighborCount : ifb.neighborCount, 64'(m_count[p]));
    chk({pre, "_tableFull"},  p == 0 ? ifa.tableFull  : ifb.tableFull,  64'(m_count[p] == N));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy_p0"}, ifa.busy, 0);
    chk({tag, "_busy_p1"}, ifb.busy, 0);
    chk({tag, "_done_p0"}, ifa.QTUFMB_done, 0);
    chk({tag, "_done_p1"}, ifb.QTUFMB_done, 0);
  endtask

  // Called at a negedge with the block idle; returns at a negedge with the block idle again.
  task automatic do_op(input logic [W-1:0] id, h, q, e, input bit dest, input bit stray);
    int exp_c;
    ifa.fSourceID = id; ifa.fSourceHops = h; ifa.fQValue = q; ifa.fEnergyLeft = e;
    ifa.iAmDestination = dest; ifa.en = 1'b1;
    @(posedge clk); #1 ifa.en = 1'b0;
    exp_c = dest ? N + 2 : 2 * N + 2;
    for (int c = 1; c <= exp_c; c++) begin
      @(negedge clk);
      chk("op_busy_p0", ifa.busy, 1);
      chk("op_busy_p1", ifb.busy, 1);
      chk("op_done_p0", ifa.QTUFMB_done, 64'(c == exp_c));
      chk("op_done_p1", ifb.QTUFMB_done, 64'(c == exp_c));
      if (stray && c == 3) begin
        ifa.fSourceID = W'($urandom_range(1, 60)); ifa.fQValue = W'($urandom_range(1, 9));
        ifa.iAmDestination = $urandom_range(0, 1) == 1; ifa.en = 1'b1;
      end
      if (stray && c == 4) ifa.en = 1'b0;
    end
    model_op(0, id, h, q, e, dest);
    model_op(1, id, h, q, e, dest);
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    chk_idle("op_after");
  endtask

  task automatic hb_clear();
    ifa.HB_Reset = 1'b1;
    @(posedge clk); #1 ifa.HB_Reset = 1'b0;
    @(negedge clk);
    model_hb();
    chk_idle("hb");
    check_dut(0);
    check_dut(1);
  endtask

  initial begin
    ifa.en = 1'b0; ifa.iAmDestination = 1'b0; ifa.HB_Reset = 1'b0;
    ifa.fSourceID = '0; ifa.fSourceHops = '0; ifa.fQValue = '0; ifa.fEnergyLeft = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    check_dut(0);
    check_dut(1);
    rst = 1'b0;

    // Single insert straight out of reset.
    do_op(16'd5, 16'd2, 16'h4000, 16'd100, 1'b0, 1'b0);
    chk("ins_chosen", ifa.chosenHop, 16'd5);
    chk("ins_index", ifa.neighborIndex, 0);
    chk("ins_count", ifa.neighborCount, 1);

    // Destination op with an en pulse while busy.
    do_op(16'd6, 16'd1, 16'h1000, 16'd50, 1'b1, 1'b1);
    chk("dest_chosen", ifa.chosenHop, 16'hffff);
    chk("dest_count", ifa.neighborCount, 2);
    chk("dest_node_held", ifa.nodeID, 16'd5);

    hb_clear();
    do_op(16'd3, 16'd1, 16'h3000, 16'd10, 1'b0, 1'b0);
    do_op(16'd7, 16'd1, 16'h5000, 16'd10, 1'b0, 1'b0);
    do_op(16'd3, 16'd1, 16'h6000, 16'd10, 1'b0, 1'b0);
    chk("upd_chosen", ifa.chosenHop, 16'd3);
    chk("upd_count", ifa.neighborCount, 2);
    chk("upd_index", ifa.neighborIndex, 0);

    hb_clear();
    do_op(16'd8, 16'd3, 16'h4000, 16'd10, 1'b0, 1'b0);
    do_op(16'd9, 16'd1, 16'h4000, 16'd10, 1'b0, 1'b0);
    chk("tie_chosen", ifa.chosenHop, 16'd9);

    hb_clear();
    for (int i = 0; i < N; i++) do_op(W'(11 + i), 16'd1, W'(i + 1), 16'd10, 1'b0, 1'b0);
    chk("fill_full", ifa.tableFull, 1);
    do_op(16'd20, 16'd1, 16'd5, 16'd10, 1'b0, 1'b0);
    chk("full_p0_chosen", ifa.chosenHop, 16'd14);
    chk("full_p1_chosen", ifb.chosenHop, 16'd20);
    chk("full_p1_index", ifb.neighborIndex, 0);

    // Heartbeat clear in the middle of SEARCH.
    ifa.fSourceID = 16'd40; ifa.fQValue = 16'd7; ifa.iAmDestination = 1'b0; ifa.en = 1'b1;
    @(posedge clk); #1 ifa.en = 1'b0;
    for (int c = 1; c <= N + 3; c++) begin
      @(negedge clk);
      chk("abort_busy", ifa.busy, 1);
      chk("abort_done", ifa.QTUFMB_done, 0);
    end
    ifa.HB_Reset = 1'b1;
    @(posedge clk); #1 ifa.HB_Reset = 1'b0;
    model_hb();
    for (int c = 0; c < N + 3; c++) begin
      @(negedge clk);
      chk_idle("abort_after");
    end
    check_dut(0);
    check_dut(1);
    do_op(16'd41, 16'd2, 16'd9, 16'd3, 1'b0, 1'b0);

    // en together with HB_Reset is dropped.
    ifa.fSourceID = 16'd50; ifa.en = 1'b1; ifa.HB_Reset = 1'b1;
    @(posedge clk); #1 begin ifa.en = 1'b0; ifa.HB_Reset = 1'b0; end
    model_hb();
    repeat (3) begin
      @(negedge clk);
      chk_idle("hb_en");
    end
    check_dut(0);
    check_dut(1);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) hb_clear();
      else do_op(W'($urandom_range(1, 6)), W'($urandom_range(0, 3)), W'($urandom_range(1, 5)),
                 W'($urandom_range(0, 3)), $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
